// File: rtl/uart_rx_if.sv
// Line-side bundle of the UART receiver: serial input plus received-byte outputs.
// The receiver connects through the slave modport; the line driver / byte consumer uses master.
interface uart_rx_if;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx,
        input  po_data,
        input  po_flag,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output po_data,
        output po_flag,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling with start/stop validation.
// Optional 3-sample majority vote around mid-bit enabled by UART_RX_MAJORITY_EN.
module uart_rx #(
    parameter int unsigned UART_BPS = 115200,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    uart_rx_if.slave bus
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF         = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W        = 13;
    localparam int unsigned BIT_W        = 3;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMPLE_CNT   = HALF + 1;
`else
    localparam int unsigned SAMPLE_CNT   = HALF;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rx_s1;
    logic               r_rx_s2;
    logic               r_rx_s3;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [CNT_W-1:0]   w_baud_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [BIT_W-1:0]   w_bit_cnt_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         r_po_data;
    logic [7:0]         w_po_data_nxt;
    logic               r_po_flag;
    logic               w_po_flag_nxt;
    logic               r_frame_err;
    logic               w_frame_err_nxt;
    logic               r_rx_busy;
    logic               w_sample_pt;
    logic               w_bit_end;
    logic               w_sample_bit;

    // Two-flop synchroniser plus edge-history flop, all idle-high
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= bus.rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_sample_pt = (r_baud_cnt == CNT_W'(SAMPLE_CNT));
    assign w_bit_end   = (r_baud_cnt == CNT_W'(BAUD_CNT_MAX - 1));

`ifdef UART_RX_MAJORITY_EN
    logic r_vote_a;
    logic r_vote_b;

    // Capture the two earlier votes; the third is the live synchronised value
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_vote_a <= 1'b1;
            r_vote_b <= 1'b1;
        end else begin
            if (r_baud_cnt == CNT_W'(HALF - 1)) r_vote_a <= r_rx_s2;
            if (r_baud_cnt == CNT_W'(HALF))     r_vote_b <= r_rx_s2;
        end
    end

    assign w_sample_bit = (r_vote_a & r_vote_b) | (r_vote_a & r_rx_s2) | (r_vote_b & r_rx_s2);
`else
    assign w_sample_bit = r_rx_s2;
`endif

    // State and datapath registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_po_data   <= 8'h00;
            r_po_flag   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_po_data   <= w_po_data_nxt;
            r_po_flag   <= w_po_flag_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_rx_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state, counters and strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_po_data_nxt   = r_po_data;
        w_po_flag_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (r_rx_s3 && !r_rx_s2) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sample_pt && w_sample_bit) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_sample_pt) w_shift_nxt = {w_sample_bit, r_shift[7:1]};
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_W'(7)) w_state_nxt   = S_STOP;
                    else                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed
                if (w_sample_pt) begin
                    w_state_nxt = S_IDLE;
                    if (w_sample_bit) begin
                        w_po_data_nxt = r_shift;
                        w_po_flag_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_state == S_IDLE || w_state_nxt == S_IDLE || w_bit_end) w_baud_nxt = '0;
        else                                                           w_baud_nxt = r_baud_cnt + CNT_W'(1);
    end

    assign bus.po_data   = r_po_data;
    assign bus.po_flag   = r_po_flag;
    assign bus.frame_err = r_frame_err;
    assign bus.rx_busy   = r_rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default baud settings (434 clocks per bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx;

    localparam int unsigned BIT   = 434;
    localparam int unsigned HALF  = 217;
    localparam int          FRAME = 10 * 434;
`ifdef UART_RX_MAJORITY_EN
    localparam int          MAJ   = 1;
`else
    localparam int          MAJ   = 0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst;

    always #5 sys_clk = ~sys_clk;

    uart_rx_if u_if();

    uart_rx u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (u_if.slave)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         flag_cnt = 0;
    int         err_cnt  = 0;
    logic [7:0] rx_log [0:15];
    time        flag_t;
    time        t0;
    int         busy_low;

    // Output monitor: log every strobe cycle
    always @(negedge sys_clk) begin
        if (u_if.po_flag) begin
            if (flag_cnt < 16) rx_log[flag_cnt] = u_if.po_data;
            flag_cnt = flag_cnt + 1;
            flag_t   = $time;
        end
        if (u_if.frame_err) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        u_if.rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    // Drive start/data/stop for n_cyc clocks, optionally inverting one clock of the line
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch_at,
                              input int n_cyc, output int busy_lo);
        logic [9:0] frame;
        frame   = {stop_b, d, 1'b0};
        busy_lo = 0;
        t0      = $time;
        for (int k = 0; k < n_cyc; k++) begin
            u_if.rx = frame[4'(k / FRAME * 0 + k / int'(BIT))] ^ (k == glitch_at);
            if (k >= 3 && k <= 4126 + MAJ && !u_if.rx_busy) busy_lo++;
            @(negedge sys_clk);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        u_if.rx = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("rst_po_data",   32'(u_if.po_data),   32'h00);
        chk("rst_po_flag",   32'(u_if.po_flag),   32'h0);
        chk("rst_frame_err", 32'(u_if.frame_err), 32'h0);
        chk("rst_rx_busy",   32'(u_if.rx_busy),   32'h0);
        sys_rst = 1'b0;
        idle(5);

        // Single good frame 0x55
        send_frame(8'h55, 1'b1, -1, FRAME, busy_low);
        idle(10);
        chk("f55_flag_cnt", 32'(flag_cnt), 32'd1);
        chk("f55_data",     32'(rx_log[0]), 32'h55);
        chk("f55_err_cnt",  32'(err_cnt), 32'd0);
        chk("f55_busy_gap", 32'(busy_low), 32'd0);
        chk("f55_busy_end", 32'(u_if.rx_busy), 32'h0);
        chk("f55_latency",  32'((flag_t - t0) / 10), 32'(4127 + MAJ));
        chk("f55_hold",     32'(u_if.po_data), 32'h55);

        // Back-to-back frames, no idle between stop and next start
        send_frame(8'hA3, 1'b1, -1, FRAME, busy_low);
        send_frame(8'h0F, 1'b1, -1, FRAME, busy_low);
        idle(10);
        chk("b2b_flag_cnt", 32'(flag_cnt), 32'd3);
        chk("b2b_first",    32'(rx_log[1]), 32'hA3);
        chk("b2b_second",   32'(rx_log[2]), 32'h0F);
        chk("b2b_err_cnt",  32'(err_cnt), 32'd0);

        // 100-cycle low glitch: false start, rejected by HALF+4 cycles
        for (int k = 0; k < int'(HALF) + 4 + MAJ; k++) begin
            u_if.rx = (k < 100) ? 1'b0 : 1'b1;
            if (k == 50) chk("glitch_busy_hi", 32'(u_if.rx_busy), 32'h1);
            @(negedge sys_clk);
        end
        chk("glitch_busy_lo",  32'(u_if.rx_busy), 32'h0);
        idle(BIT);
        chk("glitch_flag_cnt", 32'(flag_cnt), 32'd3);
        chk("glitch_err_cnt",  32'(err_cnt), 32'd0);

        // Good 0x12, then 0xFF with a low stop bit and the line held low
        send_frame(8'h12, 1'b1, -1, FRAME, busy_low);
        send_frame(8'hFF, 1'b0, -1, FRAME, busy_low);
        repeat (2 * BIT) @(negedge sys_clk);
        chk("ferr_err_cnt",  32'(err_cnt), 32'd1);
        chk("ferr_flag_cnt", 32'(flag_cnt), 32'd4);
        chk("ferr_prev",     32'(rx_log[3]), 32'h12);
        chk("ferr_data",     32'(u_if.po_data), 32'h12);
        chk("break_busy",    32'(u_if.rx_busy), 32'h0);
        idle(BIT);
        chk("break_flag_cnt", 32'(flag_cnt), 32'd4);
        chk("break_err_cnt",  32'(err_cnt), 32'd1);

        // Reset in the middle of data bit 4 of 0x3C
        send_frame(8'h3C, 1'b1, -1, 5 * int'(BIT) + int'(HALF), busy_low);
        sys_rst = 1'b1;
        u_if.rx = 1'b1;
        #1;
        chk("mrst_po_data",   32'(u_if.po_data),   32'h00);
        chk("mrst_po_flag",   32'(u_if.po_flag),   32'h0);
        chk("mrst_frame_err", 32'(u_if.frame_err), 32'h0);
        chk("mrst_rx_busy",   32'(u_if.rx_busy),   32'h0);
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        idle(BIT);
        chk("mrst_no_flag", 32'(flag_cnt), 32'd4);
        send_frame(8'h3C, 1'b1, -1, FRAME, busy_low);
        idle(10);
        chk("mrst_flag_cnt", 32'(flag_cnt), 32'd5);
        chk("mrst_logged",   32'(rx_log[4]), 32'h3C);
        chk("mrst_data",     32'(u_if.po_data), 32'h3C);

`ifdef UART_RX_MAJORITY_EN
        // One-clock inversion at the HALF vote of data bit 3 is outvoted
        send_frame(8'h81, 1'b1, 4 * int'(BIT) + int'(HALF) + 1, FRAME, busy_low);
        idle(10);
        chk("maj_flag_cnt", 32'(flag_cnt), 32'd6);
        chk("maj_data",     32'(rx_log[5]), 32'h81);
        chk("maj_err_cnt",  32'(err_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver at the line-input end of the UART path, the counterpart of the transmit stage. It synchronises the incoming serial line, detects and validates the start bit, and samples eight data bits LSB-first at mid-bit. It checks the stop bit and presents each received byte as `po_data` with a one-cycle `po_flag` strobe, the same byte/flag pairing the transmit stage accepts, so a loopback connects directly.

## Interface
- `UART_BPS`, 115200, line baud rate.
- `CLK_FREQ`, 50_000_000, `sys_clk` frequency in Hz.
- Derived: `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` (434 at defaults) and `HALF = BAUD_CNT_MAX/2` (217). Legal range of `BAUD_CNT_MAX` is 8..8191.

- `sys_clk`  input  1  system clock; single clock domain.
- `sys_rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line; idles high; asynchronous to `sys_clk`.
- `po_data`  output  8  last correctly framed byte; bit 0 is the first data bit on the line.
- `po_flag`  output  1  one-cycle strobe: `po_data` updated this cycle.
- `frame_err`  output  1  one-cycle strobe: stop bit sampled low, byte discarded.
- `rx_busy`  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Synchroniser: `rx` passes through two flops (`rx_s1`, `rx_s2`) plus an edge-history flop `rx_s3`. All three reset to 1, so reset produces no spurious edge.
- `baud_cnt`: 13 bits. Held at 0 in IDLE. Otherwise it counts 0..`BAUD_CNT_MAX`-1 and wraps. The wrap cycle is the bit boundary.
- Sample point: `baud_cnt == HALF`. The sampled value is `rx_s2` there (see Configuration).
- `bit_cnt`: 3 bits, data-bit index 0..7.
- States:
  - IDLE: on `rx_s3 == 1 && rx_s2 == 0`, go to START and clear `baud_cnt` to 0.
  - START: at the sample point, a sampled 1 is a false start; return to IDLE with no strobe. A sampled 0 means stay in START. At the bit boundary, go to DATA with `bit_cnt = 0`.
  - DATA: at each sample point, shift the sampled bit into `shift[7]` (right shift). At the bit boundary, if `bit_cnt == 7` go to STOP; otherwise increment `bit_cnt`.
  - STOP: at the sample point:
    - Sampled 1: `po_data <= shift` and `po_flag <= 1`.
    - Sampled 0: `frame_err <= 1` and `po_data` is unchanged.
    - Either way, go to IDLE on the same edge. The early return at mid-stop-bit tolerates transmitter clock skew and back-to-back frames.
- After a frame error with the line still low (break), IDLE waits for a fresh high-to-low edge. No frame starts while the line stays low.
- Reset mid-frame: state returns to IDLE, counters clear, and all outputs take their reset values. The partial byte is lost.

## Timing
- Output reset values: `po_data` = 8'h00, `po_flag` = 0, `frame_err` = 0, `rx_busy` = 0.
- Start detection: the edge is seen 3 `sys_clk` cycles after `rx` falls, from the 2-flop synchroniser plus the edge register.
- First data-bit sample: 1.5 bit periods after start detection, i.e. `BAUD_CNT_MAX + HALF` cycles.
- `po_flag` / `frame_err`:
  - Registered, asserted exactly one cycle.
  - Assertion is the cycle after the stop-bit sample point, about 9.5 bit periods plus 4 cycles after the `rx` falling edge.
  - `po_data` is valid on the same cycle as `po_flag` and holds until the next `po_flag`.
- `rx_busy`: rises the cycle after the start edge is detected. Falls the cycle after the stop-bit sample point, coincident with the strobe, or after a false-start rejection.
- `po_flag` and `frame_err` are mutually exclusive.
- Minimum frame spacing: zero idle bits. The next start edge is accepted from the first cycle in IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Registers `rx_s2` at `baud_cnt` = `HALF`-1, `HALF`, and `HALF`+1.
  - The sampled bit is the 2-of-3 majority.
  - All sample-point actions (start check, shift, stop check) move to `baud_cnt == HALF`+1. Every latency above increases by 1 cycle.
- Undefined: a single sample of `rx_s2` at `baud_cnt == HALF`. No vote registers are generated.

## Test plan
- Single frame 0x55 at defaults (434-cycle bits), stop high:
  - `po_flag` pulses once with `po_data` = 0x55 and `frame_err` = 0.
  - `rx_busy` is high throughout the frame, then returns to 0.
- Back-to-back 0xA3 then 0x0F with no idle between stop and next start: two `po_flag` pulses carrying 0xA3 then 0x0F in order.
- Low glitch of 100 cycles (< `HALF`) on an idle line:
  - No `po_flag` and no `frame_err`.
  - `rx_busy` pulses high and returns to 0 by `HALF`+4 cycles.
- Frame 0xFF with stop bit driven low, after a prior good 0x12:
  - `frame_err` pulses once and `po_flag` stays 0.
  - `po_data` remains 0x12.
  - Holding the line low afterwards produces no further activity.
- Assert `sys_rst` during data bit 4 of 0x3C:
  - All outputs go to reset values immediately.
  - After release, a complete 0x3C frame yields `po_data` = 0x3C.
- `UART_RX_MAJORITY_EN` defined, frame 0x81, `rx` inverted for exactly the `HALF` cycle of data bit 3: `po_data` = 0x81 and `po_flag` = 1.
